cpu_step_ctrl: RTL and testbench

CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

---
 rtl/cpu_step_ctrl.sv | 123 ++++++++++++
 tb/tb_cpu_step_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_step_ctrl.sv
// Single-step / free-run clock-enable controller for a 6502 core: synchronizes and
// debounces the step button and issues cpu_en pulses. Optional macro: CPU_STEP_COUNT_EN.
module cpu_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RUN_DIV         = 100
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        btn,
  input  logic        run,
  output logic        cpu_en,
  output logic        btn_db,
  output logic        busy,
  output logic [15:0] step_count
);

  localparam int              DB_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0]     DIV_MAX = 16'(RUN_DIV - 1);

  typedef enum logic [1:0] {IDLE, STEP, WAIT_REL, RUN} state_t;

  logic            btn_s1_q, btn_s2_q, run_s1_q, run_s2_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            btn_db_q, btn_db_d, btn_db_prev_q;
  logic            btn_rise;
  state_t          state_q, state_d;
  logic [15:0]     div_q, div_d;
  logic            cpu_en_q, cpu_en_d;
  logic            busy_q, busy_d;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
      run_s1_q <= 1'b0;
      run_s2_q <= 1'b0;
    end else begin
      btn_s1_q <= btn;
      btn_s2_q <= btn_s1_q;
      run_s1_q <= run;
      run_s2_q <= run_s1_q;
    end
  end

  // A new level is accepted only after holding for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    db_cnt_d = db_cnt_q;
    btn_db_d = btn_db_q;
    if (btn_s2_q == btn_db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_MAX) begin
      db_cnt_d = '0;
      btn_db_d = ~btn_db_q;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  assign btn_rise = btn_db_q & ~btn_db_prev_q;

  always_comb begin
    state_d = state_q;
    div_d   = '0;
    case (state_q)
      IDLE: begin
        if (run_s2_q)      state_d = RUN;
        else if (btn_rise) state_d = STEP;
      end
      STEP:     state_d = WAIT_REL;
      WAIT_REL: if (!btn_db_q) state_d = IDLE;
      RUN: begin
        if (!run_s2_q) state_d = btn_db_q ? WAIT_REL : IDLE;
        else           div_d   = (div_q == DIV_MAX) ? 16'd0 : div_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
    // run_s1_q is next cycle's synchronized run, so a pulse never lands in the RUN exit cycle.
    cpu_en_d = (state_d == STEP) ||
               ((state_d == RUN) && run_s1_q && (div_d == DIV_MAX));
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      db_cnt_q      <= '0;
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
      state_q       <= IDLE;
      div_q         <= '0;
      cpu_en_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      db_cnt_q      <= db_cnt_d;
      btn_db_q      <= btn_db_d;
      btn_db_prev_q <= btn_db_q;
      state_q       <= state_d;
      div_q         <= div_d;
      cpu_en_q      <= cpu_en_d;
      busy_q        <= busy_d;
    end
  end

  assign cpu_en = cpu_en_q;
  assign btn_db = btn_db_q;
  assign busy   = busy_q;

`ifdef CPU_STEP_COUNT_EN
  logic [15:0] step_cnt_q, step_cnt_d;

  assign step_cnt_d = cpu_en_q ? step_cnt_q + 16'd1 : step_cnt_q;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) step_cnt_q <= '0;
    else        step_cnt_q <= step_cnt_d;
  end

  assign step_count = step_cnt_q;
`else
  assign step_count = 16'd0;
`endif

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with DEBOUNCE_CYCLES=4, RUN_DIV=3.
module tb_cpu_step_ctrl;

`ifdef CPU_STEP_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_l, btn, run;
  logic        cpu_en, btn_db, busy;
  logic [15:0] step_count;

  always #5 clk = ~clk;

  cpu_step_ctrl #(.DEBOUNCE_CYCLES(4), .RUN_DIV(3)) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .btn        (btn),
    .run        (run),
    .cpu_en     (cpu_en),
    .btn_db     (btn_db),
    .busy       (busy),
    .step_count (step_count)
  );

  typedef struct {
    logic btn;
    logic run;
    int   tog;
    int   cycles;
    int   exp_pulses;
    logic exp_db;
    logic exp_busy;
  } vec_t;

  vec_t vecs[8];
  int   checks    = 0;
  int   errors    = 0;
  int   exp_steps = 0;
  int   viol      = 0;
  logic prev_en   = 1'b0;

  function automatic int sc(input int n);
    return CNT_EN ? (n & 32'h0000_FFFF) : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_vec(input int idx);
    vec_t v;
    int   p;
    v = vecs[idx];
    p = 0;
    for (int i = 0; i < v.cycles; i++) begin
      btn = (v.tog == 0) ? v.btn : (v.btn ^ (((i / v.tog) % 2) != 0));
      run = v.run;
      @(posedge clk);
      #1;
      if (cpu_en) p++;
    end
    exp_steps += v.exp_pulses;
    chk($sformatf("vec%0d_pulses", idx), p, v.exp_pulses);
    chk($sformatf("vec%0d_btn_db", idx), btn_db, v.exp_db);
    chk($sformatf("vec%0d_busy", idx), busy, v.exp_busy);
    chk($sformatf("vec%0d_step_count", idx), step_count, sc(exp_steps));
  endtask

  task automatic count_pulses(input int n, output int p);
    p = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (cpu_en) p++;
    end
  endtask

  // Bounded search for the first cpu_en; returns 0 if none within n edges.
  task automatic first_pulse(input int n, output int k);
    k = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (cpu_en) begin
        k = i;
        break;
      end
    end
  endtask

  // Pulses must be isolated and only ever occur while busy.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_l) begin
        if (cpu_en && prev_en) viol++;
        if (cpu_en && !busy)   viol++;
      end
      prev_en = cpu_en;
    end
  end

  initial begin
    int p, k;
    //          btn   run   tog cyc pulses db    busy
    vecs[0] = '{1'b1, 1'b0, 0, 20, 1,  1'b1, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 0, 20, 0,  1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 2, 30, 0,  1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 0, 8,  0,  1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 0, 33, 10, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 0, 12, 4,  1'b1, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 0, 10, 0,  1'b1, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 0, 12, 0,  1'b0, 1'b0};

    rst_l = 1'b0;
    btn   = 1'b0;
    run   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_btn_db", btn_db, 0);
    chk("rst_busy", busy, 0);
    chk("rst_step_count", step_count, 0);
    @(negedge clk);
    rst_l = 1'b1;

    for (int i = 0; i < 8; i++) apply_vec(i);

    // Button held across reset release is debounced afresh and steps once.
    @(posedge clk);
    #1;
    rst_l = 1'b0;
    btn   = 1'b1;
    run   = 1'b0;
    #1;
    chk("hold_rst_cpu_en", cpu_en, 0);
    chk("hold_rst_step_count", step_count, 0);
    exp_steps = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    count_pulses(20, p);
    exp_steps += 1;
    chk("hold_pulses", p, 1);
    chk("hold_step_count", step_count, sc(exp_steps));
    btn = 1'b0;
    count_pulses(20, p);
    chk("hold_rel_pulses", p, 0);
    chk("hold_rel_busy", busy, 0);

    // Reset in the middle of a free-run pulse.
    run = 1'b1;
    first_pulse(20, k);
    chk("run_first_pulse_edge", k, 5);
    #2;
    rst_l = 1'b0;
    #1;
    chk("midrun_rst_cpu_en", cpu_en, 0);
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_step_count", step_count, 0);
    exp_steps = 0;
    @(negedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    first_pulse(20, k);
    chk("post_rst_first_pulse_edge", k, 5);
    exp_steps += 1;
    run = 1'b0;
    count_pulses(10, p);
    chk("post_rst_exit_pulses", p, 0);
    chk("post_rst_exit_busy", busy, 0);
    chk("post_rst_step_count", step_count, sc(exp_steps));

`ifdef CPU_STEP_COUNT_EN
    // Counter wrap: preload 0xFFFF then take one step.
    force dut.step_cnt_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.step_cnt_q;
    #1;
    chk("preload_step_count", step_count, 16'hFFFF);
    btn = 1'b1;
    count_pulses(20, p);
    chk("wrap_pulses", p, 1);
    btn = 1'b0;
    count_pulses(20, p);
    chk("wrap_step_count", step_count, 0);
    chk("wrap_busy", busy, 0);
`endif

    chk("isolated_pulses", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
